// File: rtl/audio_stream_dsp_pkg.sv
// Shared types and helpers for the audio stream DSP stage:
// mode and FSM enums plus signed saturation limits.
package audio_dsp_pkg;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_GAIN  = 2'd1,
        MODE_VOCAL = 2'd2,
        MODE_MUTE  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        HOLD_L = 2'd1,
        EMIT_R = 2'd2
    } state_t;

    localparam int LIMIT_W = 64;

    // Largest / smallest value representable in a w-bit two's complement word.
    function automatic logic signed [LIMIT_W-1:0] sat_max(input int w);
        logic signed [LIMIT_W-1:0] one;
        one = 64'sd1;
        return (one <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [LIMIT_W-1:0] sat_min(input int w);
        logic signed [LIMIT_W-1:0] one;
        one = 64'sd1;
        return -(one <<< (w - 1));
    endfunction

endpackage

// File: rtl/audio_stream_dsp_if.sv
// Stream handshake bundle around the DSP stage: FIFO side (in_*) and codec side (out_*).
// master = the surrounding environment, slave = the DSP stage.
interface audio_stream_dsp_if #(
    parameter int IN_W     = 32,
    parameter int SAMPLE_W = 24,
    parameter int NUM_CH   = 2
);
    localparam int CH_W = $clog2(NUM_CH);

    logic [IN_W-1:0]     in_data;
    logic                in_valid;
    logic                in_sop;
    logic                in_ready;
    logic [SAMPLE_W-1:0] out_data;
    logic [CH_W-1:0]     out_channel;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output in_data, in_valid, in_sop, out_ready,
        input  in_ready, out_data, out_channel, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_sop, out_ready,
        output in_ready, out_data, out_channel, out_valid
    );

endinterface

// File: rtl/audio_stream_dsp_gain_sat.sv
// Combinational signed gain: multiply, arithmetic shift by GAIN_FRAC, saturate to SAMPLE_W.
// sat is high whenever the result had to be clamped.
module dsp_gain_sat
    import audio_dsp_pkg::*;
#(
    parameter int SAMPLE_W  = 24,
    parameter int GAIN_W    = 16,
    parameter int GAIN_FRAC = 14
) (
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic signed [GAIN_W-1:0]   gain,
    output logic        [SAMPLE_W-1:0] result,
    output logic                       sat
);
    localparam int P_W = SAMPLE_W + GAIN_W;
    localparam logic signed [P_W-1:0] MAX_P = P_W'(sat_max(SAMPLE_W));
    localparam logic signed [P_W-1:0] MIN_P = P_W'(sat_min(SAMPLE_W));

    logic signed [P_W-1:0] prod;
    logic signed [P_W-1:0] shifted;

    assign prod = $signed({{GAIN_W{sample[SAMPLE_W-1]}}, sample}) *
                  $signed({{SAMPLE_W{gain[GAIN_W-1]}}, gain});

    // Arithmetic shift floors toward -inf.
    assign shifted = prod >>> GAIN_FRAC;

    always_comb begin
        sat    = 1'b0;
        result = shifted[SAMPLE_W-1:0];
        if (shifted > MAX_P) begin
            sat    = 1'b1;
            result = MAX_P[SAMPLE_W-1:0];
        end else if (shifted < MIN_P) begin
            sat    = 1'b1;
            result = MIN_P[SAMPLE_W-1:0];
        end
    end

endmodule

// File: rtl/audio_stream_dsp.sv
// Streaming DSP stage between the sample FIFO and the codec: per-frame passthrough,
// gain with saturation, vocal cancel (L-R) or mute, with a registered output.
module audio_stream_dsp
    import audio_dsp_pkg::*;
#(
    parameter int IN_W      = 32,
    parameter int SAMPLE_W  = 24,
    parameter int NUM_CH    = 2,
    parameter int GAIN_W    = 16,
    parameter int GAIN_FRAC = 14
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          mode,
    input  logic [GAIN_W-1:0]   gain,
    audio_stream_dsp_if.slave   bus,
    output logic                sat_flag,
    input  logic                sat_clr
);
    localparam int CH_W = $clog2(NUM_CH);

    state_t              state_q, state_nxt;
    mode_t               mode_q, frame_mode;
    logic [CH_W-1:0]     cnt_q, ch;
    logic [SAMPLE_W-1:0] sample, hold_q;
    logic [SAMPLE_W-1:0] out_data_q;
    logic [CH_W-1:0]     out_ch_q;
    logic                out_valid_q, sat_q;
    logic                out_free, in_ready, accept;
    logic                load, load_sat, hold_en;
    logic [SAMPLE_W-1:0] load_data;
    logic [CH_W-1:0]     load_ch;
    logic [SAMPLE_W-1:0] half_diff, gain_in, gain_out;
    logic                diff_unused_lsb;
    logic                gain_sat;

    assign sample = bus.in_data[SAMPLE_W-1:0];

    generate
        if (IN_W > SAMPLE_W) begin : g_upper
            logic unused_upper;
            assign unused_upper = ^bus.in_data[IN_W-1:SAMPLE_W];
        end
    endgenerate

    assign out_free = !out_valid_q || bus.out_ready;
    assign in_ready = (state_q != EMIT_R) && out_free;
    assign accept   = bus.in_valid && in_ready;

    assign ch         = bus.in_sop ? '0 : cnt_q;
    assign frame_mode = (ch == '0) ? mode_t'(mode) : mode_q;

    // (L - R) in SAMPLE_W+1 bits; dropping the LSB is the arithmetic shift by one.
    assign {half_diff, diff_unused_lsb} = {hold_q[SAMPLE_W-1], hold_q} - {sample[SAMPLE_W-1], sample};

    assign gain_in = (state_q == HOLD_L) ? half_diff : sample;

    dsp_gain_sat #(
        .SAMPLE_W  (SAMPLE_W),
        .GAIN_W    (GAIN_W),
        .GAIN_FRAC (GAIN_FRAC)
    ) u_gain (
        .sample (gain_in),
        .gain   (gain),
        .result (gain_out),
        .sat    (gain_sat)
    );

    always_comb begin
        state_nxt = state_q;
        load      = 1'b0;
        load_data = gain_out;
        load_ch   = ch;
        load_sat  = 1'b0;
        hold_en   = 1'b0;
        case (state_q)
            ACCEPT: begin
                if (accept) begin
                    case (frame_mode)
                        MODE_PASS: begin
                            load      = 1'b1;
                            load_data = sample;
                        end
                        MODE_MUTE: begin
                            load      = 1'b1;
                            load_data = '0;
                        end
                        MODE_GAIN: begin
                            load     = 1'b1;
                            load_sat = gain_sat;
                        end
                        MODE_VOCAL: begin
                            if (ch == '0) begin
                                hold_en   = 1'b1;
                                state_nxt = HOLD_L;
                            end else begin
                                load     = 1'b1;
                                load_sat = gain_sat;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            HOLD_L: begin
                if (accept) begin
                    if (ch == '0) begin
                        hold_en = 1'b1;
                    end else begin
                        load      = 1'b1;
                        load_ch   = '0;
                        load_sat  = gain_sat;
                        state_nxt = EMIT_R;
                    end
                end
            end
            EMIT_R: begin
                // The ch0 result is still in out_data_q; re-issue it as ch1.
                if (out_free) begin
                    load      = 1'b1;
                    load_data = out_data_q;
                    load_ch   = CH_W'(1);
                    state_nxt = ACCEPT;
                end
            end
            default: state_nxt = ACCEPT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ACCEPT;
            mode_q  <= MODE_PASS;
            cnt_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_nxt;
            if (accept) begin
                cnt_q <= (ch == CH_W'(NUM_CH - 1)) ? '0 : ch + CH_W'(1);
                if (ch == '0)
                    mode_q <= frame_mode;
            end
            if (hold_en)
                hold_q <= sample;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            sat_q       <= 1'b0;
        end else begin
            if (load) begin
                out_valid_q <= 1'b1;
                out_data_q  <= load_data;
                out_ch_q    <= load_ch;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (load_sat)
                sat_q <= 1'b1;
            else if (sat_clr)
                sat_q <= 1'b0;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_data    = out_data_q;
    assign bus.out_channel = out_ch_q;
    assign bus.out_valid   = out_valid_q;
    assign sat_flag        = sat_q;

endmodule

// File: tb/tb_audio_stream_dsp.sv
// Bench for audio_stream_dsp: directed vector table, hand-written stall/reset sequences,
// and randomized frames checked against a frame-level arithmetic reference model.
module tb_audio_stream_dsp;
    import audio_dsp_pkg::*;

    localparam int IN_W      = 32;
    localparam int SAMPLE_W  = 24;
    localparam int NUM_CH    = 2;
    localparam int GAIN_W    = 16;
    localparam int GAIN_FRAC = 14;
    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;
    localparam longint MAXV = (longint'(1) << (SAMPLE_W - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (SAMPLE_W - 1));

    logic              clk = 1'b0;
    logic              reset_n;
    logic [1:0]        mode;
    logic [GAIN_W-1:0] gain;
    logic              sat_flag;
    logic              sat_clr;

    audio_stream_dsp_if #(.IN_W(IN_W), .SAMPLE_W(SAMPLE_W), .NUM_CH(NUM_CH)) bus ();

    audio_stream_dsp #(
        .IN_W      (IN_W),
        .SAMPLE_W  (SAMPLE_W),
        .NUM_CH    (NUM_CH),
        .GAIN_W    (GAIN_W),
        .GAIN_FRAC (GAIN_FRAC)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .mode     (mode),
        .gain     (gain),
        .bus      (bus),
        .sat_flag (sat_flag),
        .sat_clr  (sat_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic        sop;
        mode_t       md;
        logic [15:0] g;
        logic [31:0] d;
        logic        clr;
        logic        e_vld;
        logic [23:0] e_d;
        logic        e_ch;
        logic        e_sat;
        logic        e_rdy;
    } vec_t;

    typedef struct {
        logic [23:0] d;
        logic        ch;
    } exp_t;

    vec_t   vecs[32];
    int     nv = 0;
    int     n_cmp = 0;
    int     n_bad = 0;
    exp_t   exp_q[$];
    logic   model_sat;
    logic   drv_done, mon_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic vld, input logic sop, input mode_t md, input logic [15:0] g,
                           input logic [31:0] d, input logic clr, input logic e_vld,
                           input logic [23:0] e_d, input logic e_ch, input logic e_sat,
                           input logic e_rdy);
        vecs[nv] = '{vld, sop, md, g, d, clr, e_vld, e_d, e_ch, e_sat, e_rdy};
        nv++;
    endtask

    task automatic ref_gain(input logic [23:0] s, input logic [15:0] g, output logic [23:0] r);
        longint p;
        p = longint'($signed(s)) * longint'($signed(g));
        p = p >>> GAIN_FRAC;
        if (p > MAXV) begin
            r = 24'h7FFFFF;
            model_sat = 1'b1;
        end else if (p < MINV) begin
            r = 24'h800000;
            model_sat = 1'b1;
        end else begin
            r = p[23:0];
        end
    endtask

    task automatic push_frame(input mode_t md, input logic [15:0] g, input logic [31:0] w0,
                              input logic [31:0] w1);
        logic [23:0] r0, r1;
        longint      l, rr, dd;
        case (md)
            MODE_PASS: begin r0 = w0[23:0]; r1 = w1[23:0]; end
            MODE_GAIN: begin ref_gain(w0[23:0], g, r0); ref_gain(w1[23:0], g, r1); end
            MODE_MUTE: begin r0 = '0; r1 = '0; end
            default: begin
                l  = longint'($signed(w0[23:0]));
                rr = longint'($signed(w1[23:0]));
                dd = (l - rr) >>> 1;
                ref_gain(dd[23:0], g, r0);
                r1 = r0;
            end
        endcase
        exp_q.push_back('{r0, 1'b0});
        exp_q.push_back('{r1, 1'b1});
    endtask

    function automatic logic [31:0] rnd_word();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 7))
            0: w[23:0] = 24'h7FFFFF;
            1: w[23:0] = 24'h800000;
            2: w[23:0] = 24'h000000;
            default: ;
        endcase
        return w;
    endfunction

    function automatic logic [15:0] rnd_gain();
        case ($urandom_range(0, 5))
            0: return 16'h4000;
            1: return 16'h7FFF;
            2: return 16'h8000;
            3: return 16'h2000;
            default: return 16'($urandom);
        endcase
    endfunction

    // Entered and left at posedge+1; returns ok=0 if the stage never took the word.
    task automatic send(input logic sop, input mode_t md, input logic [31:0] d, output logic ok);
        if ($urandom_range(0, 3) == 0) begin
            bus.in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.in_sop   = sop;
        bus.in_data  = d;
        mode         = md;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                @(posedge clk);
                #1;
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n       = 1'b0;
        mode          = 2'd0;
        gain          = '0;
        sat_clr       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sop    = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data", 32'(bus.out_data), 32'd0);
        check("rst_ch", 32'(bus.out_channel), 32'd0);
        check("rst_sat", 32'(sat_flag), 32'd0);
        check("rst_ready", 32'(bus.in_ready), 32'd1);

        //       vld sop mode        gain      data          clr  e_vld e_data      e_ch e_sat e_rdy
        add_vec(Y, Y, MODE_PASS,  16'h0000, 32'hAB123456, N,   Y, 24'h123456, N, N, Y);
        add_vec(Y, N, MODE_PASS,  16'h0000, 32'h00FFFFFF, N,   Y, 24'hFFFFFF, Y, N, Y);
        add_vec(Y, Y, MODE_GAIN,  16'h2000, 32'h00000100, N,   Y, 24'h000080, N, N, Y);
        add_vec(Y, N, MODE_GAIN,  16'h7FFF, 32'h007FFFFF, N,   Y, 24'h7FFFFF, Y, Y, Y);
        add_vec(N, N, MODE_GAIN,  16'h7FFF, 32'h00000000, Y,   N, 24'h000000, N, N, Y);
        add_vec(Y, Y, MODE_VOCAL, 16'h4000, 32'h00000300, N,   N, 24'h000000, N, N, Y);
        add_vec(Y, N, MODE_VOCAL, 16'h4000, 32'h00000100, N,   Y, 24'h000100, N, N, N);
        add_vec(N, N, MODE_VOCAL, 16'h4000, 32'h00000000, N,   Y, 24'h000100, Y, N, Y);
        add_vec(Y, Y, MODE_VOCAL, 16'h4000, 32'h007FFFFF, N,   N, 24'h000000, N, N, Y);
        add_vec(Y, N, MODE_VOCAL, 16'h4000, 32'h00800000, N,   Y, 24'h7FFFFF, N, N, N);
        add_vec(N, N, MODE_VOCAL, 16'h4000, 32'h00000000, N,   Y, 24'h7FFFFF, Y, N, Y);
        add_vec(Y, Y, MODE_VOCAL, 16'h4000, 32'h00800000, N,   N, 24'h000000, N, N, Y);
        add_vec(Y, N, MODE_VOCAL, 16'h4000, 32'h007FFFFF, N,   Y, 24'h800000, N, N, N);
        add_vec(N, N, MODE_VOCAL, 16'h4000, 32'h00000000, N,   Y, 24'h800000, Y, N, Y);
        add_vec(Y, Y, MODE_VOCAL, 16'h4000, 32'h00000500, N,   N, 24'h000000, N, N, Y);
        add_vec(Y, Y, MODE_VOCAL, 16'h4000, 32'h00000200, N,   N, 24'h000000, N, N, Y);
        add_vec(Y, N, MODE_VOCAL, 16'h4000, 32'h00000100, N,   Y, 24'h000080, N, N, N);
        add_vec(N, N, MODE_VOCAL, 16'h4000, 32'h00000000, N,   Y, 24'h000080, Y, N, Y);
        add_vec(Y, Y, MODE_MUTE,  16'h4000, 32'h00000123, N,   Y, 24'h000000, N, N, Y);
        add_vec(Y, N, MODE_MUTE,  16'h4000, 32'h00000456, N,   Y, 24'h000000, Y, N, Y);
        add_vec(Y, Y, MODE_PASS,  16'h4000, 32'h00000010, N,   Y, 24'h000010, N, N, Y);
        add_vec(Y, N, MODE_MUTE,  16'h4000, 32'h00000020, N,   Y, 24'h000020, Y, N, Y);
        add_vec(Y, Y, MODE_GAIN,  16'h2000, 32'h00FFFFFF, N,   Y, 24'hFFFFFF, N, N, Y);
        add_vec(Y, N, MODE_GAIN,  16'h8000, 32'h00800000, N,   Y, 24'h7FFFFF, Y, Y, Y);
        add_vec(Y, Y, MODE_GAIN,  16'h7FFF, 32'h007FFFFF, Y,   Y, 24'h7FFFFF, N, Y, Y);
        add_vec(N, N, MODE_GAIN,  16'h7FFF, 32'h00000000, Y,   N, 24'h000000, N, N, Y);

        for (int i = 0; i < nv; i++) begin
            bus.in_valid = vecs[i].vld;
            bus.in_sop   = vecs[i].sop;
            bus.in_data  = vecs[i].d;
            mode         = vecs[i].md;
            gain         = vecs[i].g;
            sat_clr      = vecs[i].clr;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_vld));
            if (vecs[i].e_vld) begin
                check($sformatf("v%0d_data", i), 32'(bus.out_data), 32'(vecs[i].e_d));
                check($sformatf("v%0d_ch", i), 32'(bus.out_channel), 32'(vecs[i].e_ch));
            end
            check($sformatf("v%0d_sat", i), 32'(sat_flag), 32'(vecs[i].e_sat));
            check($sformatf("v%0d_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_rdy));
        end
        bus.in_valid = 1'b0;
        sat_clr      = 1'b0;

        // Back-pressure: hold the codec off for 5 cycles with a word waiting.
        mode          = MODE_PASS;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_sop    = 1'b1;
        bus.in_data   = 32'h000000A1;
        @(posedge clk);
        #1;
        check("bp_first_valid", 32'(bus.out_valid), 32'd1);
        bus.in_sop  = 1'b0;
        bus.in_data = 32'h000000B2;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            check("bp_hold_data", 32'(bus.out_data), 32'h000000A1);
            check("bp_hold_ch", 32'(bus.out_channel), 32'd0);
            check("bp_hold_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("bp_next_valid", 32'(bus.out_valid), 32'd1);
        check("bp_next_data", 32'(bus.out_data), 32'h000000B2);
        check("bp_next_ch", 32'(bus.out_channel), 32'd1);
        @(posedge clk);
        #1;
        check("bp_drained", 32'(bus.out_valid), 32'd0);

        // Reset while holding L: the held sample is dropped and the next word is ch0.
        mode         = MODE_VOCAL;
        gain         = 16'h4000;
        bus.in_valid = 1'b1;
        bus.in_sop   = 1'b1;
        bus.in_data  = 32'h00000600;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("rh_hold_valid", 32'(bus.out_valid), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("rh_rst_valid", 32'(bus.out_valid), 32'd0);
        check("rh_rst_data", 32'(bus.out_data), 32'd0);
        @(posedge clk);
        #1;
        reset_n      = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_sop   = 1'b0;
        bus.in_data  = 32'h00000300;
        @(posedge clk);
        #1;
        check("rh_l_valid", 32'(bus.out_valid), 32'd0);
        bus.in_data = 32'h00000100;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("rh_ch0_valid", 32'(bus.out_valid), 32'd1);
        check("rh_ch0_data", 32'(bus.out_data), 32'h00000100);
        check("rh_ch0_ch", 32'(bus.out_channel), 32'd0);
        @(posedge clk);
        #1;
        check("rh_ch1_data", 32'(bus.out_data), 32'h00000100);
        check("rh_ch1_ch", 32'(bus.out_channel), 32'd1);

        // Randomized frames with random codec back-pressure.
        sat_clr = 1'b1;
        @(posedge clk);
        #1;
        sat_clr   = 1'b0;
        model_sat = 1'b0;
        drv_done  = 1'b0;
        mon_done  = 1'b0;
        fork
            begin : drv
                logic        ok;
                mode_t       md;
                logic [15:0] g;
                logic [31:0] w0, w1;
                for (int f = 0; f < 150; f++) begin
                    md = mode_t'(2'($urandom_range(0, 3)));
                    g  = rnd_gain();
                    w0 = rnd_word();
                    w1 = rnd_word();
                    push_frame(md, g, w0, w1);
                    gain = g;
                    send(1'b1, md, w0, ok);
                    if (ok)
                        send(1'b0, mode_t'(2'($urandom_range(0, 3))), w1, ok);
                    if (!ok) begin
                        check("rnd_accept_timeout", 32'd0, 32'd1);
                        break;
                    end
                end
                drv_done = 1'b1;
            end
            begin : mon
                exp_t e;
                int   idle;
                idle = 0;
                while (!(drv_done && exp_q.size() == 0) && idle < 200) begin
                    @(negedge clk);
                    if (bus.out_valid && bus.out_ready) begin
                        idle = 0;
                        if (exp_q.size() == 0) begin
                            check("rnd_unexpected_output", 32'd1, 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            check("rnd_data", 32'(bus.out_data), 32'(e.d));
                            check("rnd_ch", 32'(bus.out_channel), 32'(e.ch));
                        end
                    end else if (drv_done) begin
                        idle++;
                    end
                end
                check("rnd_pending_left", 32'(exp_q.size()), 32'd0);
                mon_done = 1'b1;
            end
            begin : rdy
                while (!mon_done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rnd_sat_flag", 32'(sat_flag), 32'(model_sat));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
